// File: rtl/act_sequencer_if.sv
// Job/strobe bundle between a controller and the activation sequencer.
// Master drives the job request; slave drives the buffer strobes.
interface act_sequencer_if #(
  parameter int AW = 8,
  parameter int CW = 9
);
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [CW-1:0] row_count;
  logic          abort;
  logic          acc_rd_en;
  logic [AW-1:0] acc_rd_addr;
  logic          relu_en;
  logic          ub_wr_en;
  logic [AW-1:0] ub_wr_addr;
  logic          busy;
  logic          done;
  logic [CW-1:0] rows_written;

  modport master (
    output start, src_base, dst_base,
    output row_count, abort,
    input  acc_rd_en, acc_rd_addr,
    input  relu_en, ub_wr_en, ub_wr_addr,
    input  busy, done, rows_written
  );

  modport slave (
    input  start, src_base, dst_base,
    input  row_count, abort,
    output acc_rd_en, acc_rd_addr,
    output relu_en, ub_wr_en, ub_wr_addr,
    output busy, done, rows_written
  );
endinterface

// File: rtl/act_sequencer.sv
// Streams rows accumulator -> ReLU -> unified buffer,
// one row per cycle, two-cycle issue-to-write latency.
module act_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 9
) (
  input logic           clk,
  input logic           reset,
  act_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_a1;
  logic [ADDR_WIDTH-1:0] r_a2;
  logic                  r_v1;
  logic                  r_v2;
  logic [CNT_WIDTH-1:0]  r_left;
  logic [CNT_WIDTH-1:0]  r_rows;
  logic                  w_issue;

  // abort must suppress the read in the very cycle it is seen
  assign w_issue = (r_state == S_ISSUE) && !bus.abort;

  // FSM, address counters and relu/write pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_wr_ptr  <= '0;
      r_a1      <= '0;
      r_a2      <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_left    <= '0;
      r_rows    <= '0;
    end else begin
      r_v1 <= w_issue;
      r_v2 <= r_v1;
      r_a2 <= r_a1;
      if (r_v2)
        r_rows <= r_rows + 1'b1;
      if (w_issue) begin
        r_a1      <= r_wr_ptr;
        r_rd_addr <= r_rd_addr + 1'b1;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_left    <= r_left - 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rows <= '0;
            if (bus.row_count != '0) begin
              r_rd_addr <= bus.src_base;
              r_wr_ptr  <= bus.dst_base;
              r_left    <= bus.row_count;
              r_state   <= S_ISSUE;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (bus.abort || r_left == CNT_WIDTH'(1))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // relu stage empty => last write lands this cycle
          if (!r_v1)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.acc_rd_en    = w_issue;
  assign bus.acc_rd_addr  = r_rd_addr;
  assign bus.relu_en      = r_v1;
  assign bus.ub_wr_en     = r_v2;
  assign bus.ub_wr_addr   = r_a2;
  assign bus.busy         = (r_state == S_ISSUE) ||
                            (r_state == S_DRAIN);
  assign bus.done         = (r_state == S_DONE);
  assign bus.rows_written = r_rows;

endmodule

// File: tb/tb_act_sequencer.sv
// Directed bench for act_sequencer: timing of read,
// relu and write strobes, abort, wrap, restart, reset.
module tb_act_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  act_sequencer_if #(.AW(8), .CW(9)) u_if ();

  act_sequencer #(
    .ADDR_WIDTH(8),
    .CNT_WIDTH (9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, 32'(u_if.acc_rd_en), 0);
    check({tag, "_rd_a"}, 32'(u_if.acc_rd_addr), 0);
    check({tag, "_relu"}, 32'(u_if.relu_en), 0);
    check({tag, "_wr_en"}, 32'(u_if.ub_wr_en), 0);
    check({tag, "_wr_a"}, 32'(u_if.ub_wr_addr), 0);
    check({tag, "_busy"}, 32'(u_if.busy), 0);
    check({tag, "_done"}, 32'(u_if.done), 0);
    check({tag, "_rows"}, 32'(u_if.rows_written), 0);
  endtask

  // cycle 0 presents start; read k expected in cycle k+1,
  // relu at k+2, write at k+3; exp_done given by hand
  task automatic run_job(input string nm,
                         input logic [7:0] src,
                         input logic [7:0] dst,
                         input logic [8:0] cnt,
                         input int ab_cyc,
                         input bit repulse,
                         input int exp_n,
                         input int exp_done);
    int rdn, rln, wrn, dcyc;
    logic [7:0] ea;
    rdn = 0; rln = 0; wrn = 0; dcyc = -1;
    for (int c = 0; c < 60 && dcyc < 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        u_if.start     = 1'b1;
        u_if.src_base  = src;
        u_if.dst_base  = dst;
        u_if.row_count = cnt;
      end else if (repulse && c == 2) begin
        u_if.start     = 1'b1;
        u_if.src_base  = 8'h55;
        u_if.dst_base  = 8'h66;
        u_if.row_count = 9'd7;
      end else begin
        u_if.start = 1'b0;
      end
      u_if.abort = (c == ab_cyc);
      #1;
      if (c == 1)
        check({nm, "_busy1"}, 32'(u_if.busy),
              32'(cnt != 0));
      if (u_if.acc_rd_en) begin
        ea = src + 8'(rdn);
        check({nm, "_rd_a"}, 32'(u_if.acc_rd_addr), 32'(ea));
        check({nm, "_rd_t"}, c, rdn + 1);
        rdn++;
      end
      if (u_if.relu_en) begin
        check({nm, "_relu_t"}, c, rln + 2);
        rln++;
      end
      if (u_if.ub_wr_en) begin
        ea = dst + 8'(wrn);
        check({nm, "_wr_a"}, 32'(u_if.ub_wr_addr), 32'(ea));
        check({nm, "_wr_t"}, c, wrn + 3);
        wrn++;
      end
      if (u_if.done) begin
        dcyc = c;
        check({nm, "_busy_d"}, 32'(u_if.busy), 0);
        check({nm, "_rows"}, 32'(u_if.rows_written),
              32'(exp_n));
      end
    end
    u_if.start = 1'b0;
    u_if.abort = 1'b0;
    check({nm, "_n_rd"}, rdn, exp_n);
    check({nm, "_n_relu"}, rln, exp_n);
    check({nm, "_n_wr"}, wrn, exp_n);
    check({nm, "_done_t"}, dcyc, exp_done);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    u_if.start     = 1'b0;
    u_if.src_base  = '0;
    u_if.dst_base  = '0;
    u_if.row_count = '0;
    u_if.abort     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    // basic 4-row job: done at cycle 7
    run_job("basic", 8'h10, 8'h80, 9'd4, -1, 0, 4, 7);
    // zero rows, immediately after previous done
    run_job("zero", 8'h22, 8'h33, 9'd0, -1, 0, 0, 1);
    // address wrap FE,FF,00 / FF,00,01
    run_job("wrap", 8'hFE, 8'hFF, 9'd3, -1, 0, 3, 6);
    // abort during 4th issue cycle
    run_job("abort", 8'h00, 8'h50, 9'd10, 4, 0, 3, 6);
    // start re-pulsed while busy is ignored
    run_job("repulse", 8'h40, 8'hA0, 9'd5, -1, 1, 5, 8);
    // abort on the very first issue cycle
    run_job("abort0", 8'h70, 8'h90, 9'd6, 1, 0, 0, 3);

    // idle abort has no effect; rows_written holds
    @(negedge clk);
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    #1;
    check("idle_busy", 32'(u_if.busy), 0);
    check("idle_rows", 32'(u_if.rows_written), 0);

    // asynchronous reset in the middle of ISSUE
    @(negedge clk);
    u_if.start     = 1'b1;
    u_if.src_base  = 8'h20;
    u_if.dst_base  = 8'h30;
    u_if.row_count = 9'd10;
    @(negedge clk);
    u_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_busy", 32'(u_if.busy), 1);
    check("mid_wr", 32'(u_if.ub_wr_en), 1);
    #2;
    reset = 1'b0;
    #1;
    check_zero("arst");
    @(negedge clk);
    reset = 1'b1;
    run_job("after", 8'h30, 8'h40, 9'd2, -1, 0, 2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
